if_fetch_unit: RTL and testbench

IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

---
 rtl/if_fetch_unit.sv | 175 +++++++++++++++++
 tb/tb_if_fetch_unit.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Instruction fetch unit: issues word fetches to instruction memory under a
// two-slot credit, buffers responses and presents {PC, Inst} to decode.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        CLK,
  input  logic        RST,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        inst_valid,
  output logic [31:0] PC,
  output logic [31:0] Inst
);

  localparam logic [31:0] RESET_PC_A = RESET_PC & 32'hFFFF_FFFC;

  logic [31:0] fpc_r, fpc_n_s;
  logic [31:0] ifq_pc_r [0:1];
  logic [31:0] ifq_pc_n_s [0:1];
  logic [1:0]  ifq_cnt_r, ifq_cnt_n_s, ifq_mid_s;
  logic [31:0] fifo_pc_r [0:1];
  logic [31:0] fifo_pc_n_s [0:1];
  logic [31:0] fifo_inst_r [0:1];
  logic [31:0] fifo_inst_n_s [0:1];
  logic [1:0]  fifo_cnt_r, fifo_cnt_n_s, fifo_mid_s;
  logic [1:0]  kill_r, kill_n_s;
  logic        inst_valid_r, inst_valid_n_s;
  logic [31:0] inst_r, inst_n_s;

  logic        pop_s;
  logic [2:0]  occ_s;
  logic        xfer_s;
  logic        rsp_s;
  logic        keep_s;

  // The credit counts the slot freed by this cycle's pop so a 1-cycle memory
  // sustains one instruction per cycle without ever exceeding two entries.
  assign pop_s     = (fifo_cnt_r != 2'd0) && !stall && !redirect;
  assign occ_s     = {1'b0, ifq_cnt_r} + {1'b0, fifo_cnt_r} - {2'b00, pop_s};
  assign imem_req  = !RST && !redirect && (occ_s < 3'd2);
  assign imem_addr = fpc_r;
  assign xfer_s    = imem_req && imem_gnt;
  assign rsp_s     = imem_rvalid && (ifq_cnt_r != 2'd0);
  assign keep_s    = rsp_s && (kill_r == 2'd0) && !redirect;

  assign inst_valid = inst_valid_r;
  assign PC         = fifo_pc_r[0];
  assign Inst       = inst_r;

  // Next-state logic for fetch PC, in-flight queue, instruction FIFO and kill count
  always_comb begin
    fpc_n_s          = fpc_r;
    ifq_pc_n_s[0]    = ifq_pc_r[0];
    ifq_pc_n_s[1]    = ifq_pc_r[1];
    ifq_cnt_n_s      = ifq_cnt_r;
    ifq_mid_s        = ifq_cnt_r;
    fifo_pc_n_s[0]   = fifo_pc_r[0];
    fifo_pc_n_s[1]   = fifo_pc_r[1];
    fifo_inst_n_s[0] = fifo_inst_r[0];
    fifo_inst_n_s[1] = fifo_inst_r[1];
    fifo_cnt_n_s     = fifo_cnt_r;
    fifo_mid_s       = fifo_cnt_r;
    kill_n_s         = kill_r;
    inst_valid_n_s   = 1'b0;
    inst_n_s         = NOP_INST;

    if (redirect) begin
      fpc_n_s = redirect_pc & 32'hFFFF_FFFC;
    end else if (xfer_s) begin
      fpc_n_s = fpc_r + 32'd4;
    end else begin
      fpc_n_s = fpc_r;
    end

    if (rsp_s) begin
      ifq_pc_n_s[0] = ifq_pc_r[1];
      ifq_mid_s     = ifq_cnt_r - 2'd1;
    end else begin
      ifq_mid_s     = ifq_cnt_r;
    end
    if (xfer_s) begin
      if (ifq_mid_s == 2'd0) begin
        ifq_pc_n_s[0] = fpc_r;
      end else begin
        ifq_pc_n_s[1] = fpc_r;
      end
      ifq_cnt_n_s = ifq_mid_s + 2'd1;
    end else begin
      ifq_cnt_n_s = ifq_mid_s;
    end

    // Entries are left in place on flush so PC keeps showing the last instruction.
    if (redirect) begin
      fifo_cnt_n_s = 2'd0;
    end else begin
      if (pop_s) begin
        if (fifo_cnt_r == 2'd2) begin
          fifo_pc_n_s[0]   = fifo_pc_r[1];
          fifo_inst_n_s[0] = fifo_inst_r[1];
        end else begin
          fifo_pc_n_s[0]   = fifo_pc_r[0];
        end
        fifo_mid_s = fifo_cnt_r - 2'd1;
      end else begin
        fifo_mid_s = fifo_cnt_r;
      end
      if (keep_s) begin
        if (fifo_mid_s == 2'd0) begin
          fifo_pc_n_s[0]   = ifq_pc_r[0];
          fifo_inst_n_s[0] = imem_rdata;
        end else begin
          fifo_pc_n_s[1]   = ifq_pc_r[0];
          fifo_inst_n_s[1] = imem_rdata;
        end
        fifo_cnt_n_s = fifo_mid_s + 2'd1;
      end else begin
        fifo_cnt_n_s = fifo_mid_s;
      end
    end

    if (redirect) begin
      kill_n_s = ifq_cnt_r - {1'b0, rsp_s};
    end else if (rsp_s && (kill_r != 2'd0)) begin
      kill_n_s = kill_r - 2'd1;
    end else begin
      kill_n_s = kill_r;
    end

    inst_valid_n_s = (fifo_cnt_n_s != 2'd0);
    if (inst_valid_n_s) begin
      inst_n_s = fifo_inst_n_s[0];
    end else begin
      inst_n_s = NOP_INST;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      fpc_r          <= RESET_PC_A;
      ifq_pc_r[0]    <= 32'h0000_0000;
      ifq_pc_r[1]    <= 32'h0000_0000;
      ifq_cnt_r      <= 2'd0;
      fifo_pc_r[0]   <= RESET_PC_A;
      fifo_pc_r[1]   <= RESET_PC_A;
      fifo_inst_r[0] <= NOP_INST;
      fifo_inst_r[1] <= NOP_INST;
      fifo_cnt_r     <= 2'd0;
      kill_r         <= 2'd0;
      inst_valid_r   <= 1'b0;
      inst_r         <= NOP_INST;
    end else begin
      fpc_r          <= fpc_n_s;
      ifq_pc_r[0]    <= ifq_pc_n_s[0];
      ifq_pc_r[1]    <= ifq_pc_n_s[1];
      ifq_cnt_r      <= ifq_cnt_n_s;
      fifo_pc_r[0]   <= fifo_pc_n_s[0];
      fifo_pc_r[1]   <= fifo_pc_n_s[1];
      fifo_inst_r[0] <= fifo_inst_n_s[0];
      fifo_inst_r[1] <= fifo_inst_n_s[1];
      fifo_cnt_r     <= fifo_cnt_n_s;
      kill_r         <= kill_n_s;
      inst_valid_r   <= inst_valid_n_s;
      inst_r         <= inst_n_s;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: a small in-order memory model answers
// grants; a second instance exercises a wrapping RESET_PC.
module tb_if_fetch_unit;

  logic        CLK = 1'b0;
  logic        RST;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        redirect, stall, inst_valid;
  logic [31:0] redirect_pc, PC, Inst;

  logic        imem_req2, imem_gnt2, imem_rvalid2, inst_valid2;
  logic [31:0] imem_addr2, imem_rdata2, PC2, Inst2;

  int checks = 0;
  int errors = 0;
  logic [31:0] pend [$];

  localparam logic [31:0] NOP = 32'h0000_0013;

  if_fetch_unit dut (
    .CLK(CLK), .RST(RST), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc), .stall(stall),
    .inst_valid(inst_valid), .PC(PC), .Inst(Inst)
  );

  if_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
    .CLK(CLK), .RST(RST), .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_gnt(imem_gnt2), .imem_rvalid(imem_rvalid2), .imem_rdata(imem_rdata2),
    .redirect(1'b0), .redirect_pc(32'h0000_0000), .stall(1'b0),
    .inst_valid(inst_valid2), .PC(PC2), .Inst(Inst2)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Apply inputs just after the falling edge; the memory answers the oldest grant.
  task automatic drive(input logic g, input logic rv_en, input logic st,
                       input logic rd, input logic [31:0] rpc);
    imem_gnt = g; stall = st; redirect = rd; redirect_pc = rpc;
    if (rv_en && pend.size() > 0) begin
      imem_rvalid = 1'b1; imem_rdata = ~pend[0];
    end else begin
      imem_rvalid = 1'b0; imem_rdata = 32'h0000_0000;
    end
    #1;
  endtask

  task automatic advance();
    if (imem_req && imem_gnt) pend.push_back(imem_addr);
    if (imem_rvalid && pend.size() > 0) pend.delete(0);
    @(negedge CLK);
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    imem_rvalid = 1'b1; imem_rdata = 32'h1111_1111; #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", imem_req); end
    checks++; if (imem_req2 !== 1'b0) begin errors++; $display("FAIL reset_req2: got %b expected 0", imem_req2); end
    advance();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    imem_rvalid = 1'b1; imem_rdata = 32'h2222_2222; #1;
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", inst_valid); end
    checks++; if (PC !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected 00000000", PC); end
    checks++; if (Inst !== NOP) begin errors++; $display("FAIL reset_inst: got %h expected %h", Inst, NOP); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req_hold: got %b expected 0", imem_req); end
    checks++; if (PC2 !== 32'hFFFF_FFF8) begin errors++; $display("FAIL reset_pc2: got %h expected fffffff8", PC2); end
    checks++; if (inst_valid2 !== 1'b0) begin errors++; $display("FAIL reset_valid2: got %b expected 0", inst_valid2); end
    advance();
    RST = 1'b0; imem_rvalid = 1'b0;
    pend.delete();
  endtask

  task automatic test_stream();
    logic [31:0] ea, ep;
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      ea = 32'(4 * k);
      checks++; if (imem_req !== 1'b1 || imem_addr !== ea) begin errors++; $display("FAIL stream_addr[%0d]: got req=%b addr=%h expected req=1 addr=%h", k, imem_req, imem_addr, ea); end
      if (k >= 2) begin
        ep = 32'(4 * (k - 2));
        checks++; if (inst_valid !== 1'b1 || PC !== ep || Inst !== ~ep) begin errors++; $display("FAIL stream_out[%0d]: got v=%b pc=%h inst=%h expected v=1 pc=%h inst=%h", k, inst_valid, PC, Inst, ep, ~ep); end
      end else begin
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL stream_early[%0d]: got v=%b expected 0", k, inst_valid); end
      end
      advance();
    end
  endtask

  task automatic test_stall();
    logic [31:0] e;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_req[%0d]: got %b expected 0", i, imem_req); end
      checks++; if (inst_valid !== 1'b1 || PC !== 32'd24 || Inst !== ~32'd24) begin errors++; $display("FAIL stall_hold[%0d]: got v=%b pc=%h inst=%h expected v=1 pc=00000018", i, inst_valid, PC, Inst); end
      advance();
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      e = 32'(32 + 4 * i);
      checks++; if (imem_req !== 1'b1 || imem_addr !== e) begin errors++; $display("FAIL release_addr[%0d]: got req=%b addr=%h expected %h", i, imem_req, imem_addr, e); end
      e = 32'(24 + 4 * i);
      checks++; if (inst_valid !== 1'b1 || PC !== e) begin errors++; $display("FAIL release_pc[%0d]: got v=%b pc=%h expected %h", i, inst_valid, PC, e); end
      advance();
    end
  endtask

  task automatic test_redirect();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'd48 || PC !== 32'd40) begin errors++; $display("FAIL redir_pre: got req=%b addr=%h pc=%h expected 1/00000030/00000028", imem_req, imem_addr, PC); end
    advance();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0102);
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL redir_req: got %b expected 0", imem_req); end
    advance();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    checks++; if (imem_req !== 1'b0 || inst_valid !== 1'b0 || PC !== 32'd40) begin errors++; $display("FAIL redir_drop1: got req=%b v=%b pc=%h expected 0/0/00000028", imem_req, inst_valid, PC); end
    advance();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100 || inst_valid !== 1'b0) begin errors++; $display("FAIL redir_target: got req=%b addr=%h v=%b expected 1/00000100/0", imem_req, imem_addr, inst_valid); end
    advance();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    checks++; if (imem_addr !== 32'h104 || inst_valid !== 1'b0) begin errors++; $display("FAIL redir_drop2: got addr=%h v=%b expected 00000104/0", imem_addr, inst_valid); end
    advance();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    checks++; if (inst_valid !== 1'b1 || PC !== 32'h100 || Inst !== ~32'h100) begin errors++; $display("FAIL redir_first: got v=%b pc=%h inst=%h expected 1/00000100/fffffeff", inst_valid, PC, Inst); end
    advance();
  endtask

  task automatic test_gnt_low();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h10C) begin errors++; $display("FAIL gnt_low_addr[%0d]: got req=%b addr=%h expected 1/0000010c", i, imem_req, imem_addr); end
      if (i >= 2) begin
        checks++; if (inst_valid !== 1'b0 || Inst !== NOP || PC !== 32'h108) begin errors++; $display("FAIL gnt_low_empty[%0d]: got v=%b inst=%h pc=%h expected 0/%h/00000108", i, inst_valid, Inst, PC, NOP); end
      end else begin
        checks++; if (inst_valid !== 1'b1 || PC !== 32'(32'h104 + 4 * i)) begin errors++; $display("FAIL gnt_low_drain[%0d]: got v=%b pc=%h", i, inst_valid, PC); end
      end
      advance();
    end
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    checks++; if (imem_addr !== 32'h10C || inst_valid !== 1'b0) begin errors++; $display("FAIL gnt_resume: got addr=%h v=%b expected 0000010c/0", imem_addr, inst_valid); end
    advance();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    checks++; if (imem_addr !== 32'h110) begin errors++; $display("FAIL gnt_resume_next: got %h expected 00000110", imem_addr); end
    advance();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    checks++; if (inst_valid !== 1'b1 || PC !== 32'h10C) begin errors++; $display("FAIL gnt_resume_out: got v=%b pc=%h expected 1/0000010c", inst_valid, PC); end
    advance();
  endtask

  task automatic test_redirect_rvalid_stall();
    drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0200);
    checks++; if (imem_req !== 1'b0 || imem_rvalid !== 1'b1) begin errors++; $display("FAIL rrs_req: got req=%b rvalid=%b expected 0/1", imem_req, imem_rvalid); end
    advance();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    checks++; if (inst_valid !== 1'b0 || Inst !== NOP || PC !== 32'h110) begin errors++; $display("FAIL rrs_flush: got v=%b inst=%h pc=%h expected 0/%h/00000110", inst_valid, Inst, PC, NOP); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin errors++; $display("FAIL rrs_addr: got req=%b addr=%h expected 1/00000200", imem_req, imem_addr); end
    advance();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    advance();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    checks++; if (inst_valid !== 1'b1 || PC !== 32'h200 || Inst !== ~32'h200) begin errors++; $display("FAIL rrs_first: got v=%b pc=%h inst=%h expected 1/00000200", inst_valid, PC, Inst); end
    advance();
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    advance();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0300);
    advance();
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0400);
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL b2b_req: got %b expected 0", imem_req); end
    advance();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h400 || inst_valid !== 1'b0) begin errors++; $display("FAIL b2b_target: got req=%b addr=%h v=%b expected 1/00000400/0", imem_req, imem_addr, inst_valid); end
    advance();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL b2b_stale: got v=%b pc=%h expected 0", inst_valid, PC); end
    advance();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    checks++; if (inst_valid !== 1'b1 || PC !== 32'h400 || Inst !== ~32'h400) begin errors++; $display("FAIL b2b_first: got v=%b pc=%h inst=%h expected 1/00000400", inst_valid, PC, Inst); end
    advance();
  endtask

  task automatic test_wrap();
    imem_gnt2 = 1'b1; imem_rvalid2 = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    checks++; if (imem_req2 !== 1'b1 || imem_addr2 !== 32'hFFFF_FFF8) begin errors++; $display("FAIL wrap_a0: got req=%b addr=%h expected 1/fffffff8", imem_req2, imem_addr2); end
    advance();
    imem_rvalid2 = 1'b1; imem_rdata2 = ~32'hFFFF_FFF8;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    checks++; if (imem_addr2 !== 32'hFFFF_FFFC || inst_valid2 !== 1'b0) begin errors++; $display("FAIL wrap_a1: got addr=%h v=%b expected fffffffc/0", imem_addr2, inst_valid2); end
    advance();
    imem_rdata2 = ~32'hFFFF_FFFC;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    checks++; if (imem_req2 !== 1'b1 || imem_addr2 !== 32'h0) begin errors++; $display("FAIL wrap_a2: got req=%b addr=%h expected 1/00000000", imem_req2, imem_addr2); end
    checks++; if (inst_valid2 !== 1'b1 || PC2 !== 32'hFFFF_FFF8 || Inst2 !== 32'h0000_0007) begin errors++; $display("FAIL wrap_out0: got v=%b pc=%h inst=%h expected 1/fffffff8/00000007", inst_valid2, PC2, Inst2); end
    advance();
    imem_rvalid2 = 1'b0; imem_gnt2 = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    checks++; if (inst_valid2 !== 1'b1 || PC2 !== 32'hFFFF_FFFC || Inst2 !== 32'h0000_0003) begin errors++; $display("FAIL wrap_out1: got v=%b pc=%h inst=%h expected 1/fffffffc/00000003", inst_valid2, PC2, Inst2); end
    advance();
  endtask

  initial begin
    RST = 1'b1;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    redirect = 1'b0; redirect_pc = 32'h0; stall = 1'b0;
    imem_gnt2 = 1'b0; imem_rvalid2 = 1'b0; imem_rdata2 = 32'h0;
    @(negedge CLK);
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_gnt_low();
    test_redirect_rvalid_stall();
    test_back_to_back();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
